// File: rtl/dispatch_window.sv
// Dispatch window: FETCH_WIDTH-slot in-order buffer between rename and the type sorter.
// Consumed slots compact toward slot 0; a new op group is appended above the survivors.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 64
`endif

module dispatch_window #(
   parameter int FETCH_WIDTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0]  in_ops,
   input  logic [FETCH_WIDTH-1:0]                 in_valid,
   output logic                                   in_ready,
   output logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0]  win_ops,
   output logic [FETCH_WIDTH-1:0]                 win_valid,
   input  logic [FETCH_WIDTH-1:0]                 win_used,
   output logic [$clog2(FETCH_WIDTH+1)-1:0]       occupancy
);

   localparam int OP_W  = `RENAMED_OP_SZ;
   localparam int OCC_W = $clog2(FETCH_WIDTH+1);

   logic [OP_W-1:0]        r_ops [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] r_valid;
   logic [OCC_W-1:0]       r_occ;

   logic [OP_W-1:0]        w_ops_nxt [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] w_valid_nxt;
   logic [FETCH_WIDTH-1:0] w_used_eff;
   logic [FETCH_WIDTH-1:0] w_surv;
   logic [OCC_W-1:0]       w_occ_nxt;
   logic                   w_run;
   logic                   w_ready;
   int                     w_n_used;
   int                     w_n_in;
   int                     w_n_acc;
   int                     w_pos;

   // Capacity check uses counts only, so in_ops never reaches in_ready.
   always_comb begin
      w_used_eff = win_used & r_valid;
      w_surv     = r_valid & ~win_used;
      w_n_used   = 0;
      w_n_in     = 0;
      w_run      = 1'b1;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_n_used = w_n_used + int'(w_used_eff[i]);
         w_run    = w_run & in_valid[i];
         w_n_in   = w_n_in + int'(w_run);
      end
      w_ready = !flush && ((int'(r_occ) - w_n_used + w_n_in) <= FETCH_WIDTH);
      w_n_acc = w_ready ? w_n_in : 0;
   end

   // Survivors take the lowest slots in order; accepted ops land directly above them.
   always_comb begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         w_ops_nxt[j] = '0;
      end
      w_pos = 0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (w_surv[i]) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
               if (j == w_pos) begin
                  w_ops_nxt[j] = r_ops[i];
               end
            end
            w_pos = w_pos + 1;
         end
      end
      for (int t = 0; t < FETCH_WIDTH; t++) begin
         if (t < w_n_acc) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
               if (j == w_pos + t) begin
                  w_ops_nxt[j] = in_ops[t*OP_W +: OP_W];
               end
            end
         end
      end
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         w_valid_nxt[j] = (j < w_pos + w_n_acc);
      end
      w_occ_nxt = OCC_W'(w_pos + w_n_acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int j = 0; j < FETCH_WIDTH; j++) begin
            r_ops[j] <= '0;
         end
      end else if (flush) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int j = 0; j < FETCH_WIDTH; j++) begin
            r_ops[j] <= '0;
         end
      end else begin
         r_valid <= w_valid_nxt;
         r_occ   <= w_occ_nxt;
         for (int j = 0; j < FETCH_WIDTH; j++) begin
            r_ops[j] <= w_ops_nxt[j];
         end
      end
   end

   always_comb begin
      win_ops = '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         win_ops[j*OP_W +: OP_W] = r_ops[j];
      end
      win_valid = r_valid;
      occupancy = r_occ;
      in_ready  = w_ready;
   end

endmodule

// File: tb/tb_dispatch_window.sv
// Bench for dispatch_window: directed scenarios plus random traffic, compared
// against a queue model of the window (oldest op at the queue front).
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 64
`endif

module tb_dispatch_window;

   localparam int FW = 4;
   localparam int OW = `RENAMED_OP_SZ;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [FW*OW-1:0] in_ops;
   logic [FW-1:0]    in_valid;
   logic             in_ready;
   logic [FW*OW-1:0] win_ops;
   logic [FW-1:0]    win_valid;
   logic [FW-1:0]    win_used;
   logic [2:0]       occupancy;

   int n_checks = 0;
   int n_errors = 0;
   logic [OW-1:0] mq[$];

   always #5 clk = ~clk;

   dispatch_window #(.FETCH_WIDTH(FW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_ops    (in_ops),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .win_ops   (win_ops),
      .win_valid (win_valid),
      .win_used  (win_used),
      .occupancy (occupancy)
   );

   task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int run_len(input logic [FW-1:0] v);
      int n = 0;
      for (int i = 0; i < FW; i++) begin
         if (!v[i]) break;
         n++;
      end
      return n;
   endfunction

   function automatic logic [FW*OW-1:0] pack4(input logic [OW-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [OW-1:0] rnd_op();
      return {$urandom, $urandom};
   endfunction

   task automatic check_state(input string tag);
      logic [FW-1:0] m = '0;
      for (int i = 0; i < mq.size(); i++) m[i] = 1'b1;
      check({tag, ".valid"}, OW'(win_valid), OW'(m));
      check({tag, ".occ"}, OW'(occupancy), OW'(mq.size()));
      for (int i = 0; i < mq.size(); i++) begin
         check($sformatf("%s.slot%0d", tag, i), win_ops[i*OW +: OW], mq[i]);
      end
   endtask

   // Called at a negedge: drive, check in_ready, clock once, update model, check state.
   task automatic step(input string tag, input logic f, input logic [FW-1:0] iv,
                       input logic [FW-1:0] used, input logic [FW*OW-1:0] ops);
      logic [FW-1:0] m = '0;
      logic [OW-1:0] nq[$];
      int nu, nin;
      logic exp_rdy;
      flush    = f;
      in_valid = iv;
      win_used = used;
      in_ops   = ops;
      #1;
      for (int i = 0; i < mq.size(); i++) m[i] = 1'b1;
      nu      = $countones(used & m);
      nin     = run_len(iv);
      exp_rdy = !f && ((mq.size() - nu + nin) <= FW);
      check({tag, ".rdy"}, OW'(in_ready), OW'(exp_rdy));
      @(posedge clk);
      if (f) begin
         mq.delete();
      end else begin
         for (int i = 0; i < mq.size(); i++) if (!used[i]) nq.push_back(mq[i]);
         if (exp_rdy) for (int t = 0; t < nin; t++) nq.push_back(ops[t*OW +: OW]);
         mq = nq;
      end
      @(negedge clk);
      check_state(tag);
   endtask

   localparam logic [OW-1:0] A = 64'hA0A0, B = 64'hB1B1, C = 64'hC2C2, D = 64'hD3D3;
   localparam logic [OW-1:0] E = 64'hE4E4, F = 64'hF5F5, P = 64'h1111, Q = 64'h2222;
   localparam logic [OW-1:0] R = 64'h3333, X = 64'hDEAD;

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 4'b0111;
      win_used = '0;
      in_ops   = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst.valid", OW'(win_valid), '0);
      check("rst.occ", OW'(occupancy), '0);
      check("rst.ops", win_ops[OW-1:0] | win_ops[2*OW-1:OW] | win_ops[3*OW-1:2*OW] | win_ops[4*OW-1:3*OW], '0);
      check("rst.rdy", OW'(in_ready), 64'd1);
      rst      = 1'b0;
      in_valid = '0;

      step("fill",    0, 4'b0111, 4'b0000, pack4(A, B, C, X));
      step("fill4",   0, 4'b0001, 4'b0000, pack4(D, X, X, X));
      step("compact", 0, 4'b0000, 4'b0101, '0);
      step("flush1",  1, 4'b1111, 4'b0011, pack4(X, X, X, X));
      step("refill",  0, 4'b1111, 4'b0000, pack4(A, B, C, D));
      step("remfill", 0, 4'b0011, 4'b0011, pack4(E, F, X, X));
      step("stall1",  0, 4'b0001, 4'b0000, pack4(X, X, X, X));
      step("stall2",  0, 4'b0001, 4'b0000, pack4(X, X, X, X));
      step("nin0",    0, 4'b0000, 4'b0000, '0);
      step("drain",   0, 4'b0000, 4'b0111, '0);
      step("noncont", 0, 4'b1101, 4'b0000, pack4(P, X, Q, R));
      step("badused", 0, 4'b0000, 4'b1100, '0);
      step("top",     0, 4'b0011, 4'b0000, pack4(A, B, X, X));
      step("flushf",  1, 4'b1111, 4'b1111, pack4(C, D, E, F));

      step("pre_rst", 0, 4'b0111, 4'b0000, pack4(A, B, C, X));
      in_valid = 4'b0001;
      in_ops   = pack4(D, X, X, X);
      #2 rst = 1'b1;
      #1;
      check("arst.valid", OW'(win_valid), '0);
      check("arst.occ", OW'(occupancy), '0);
      check("arst.ops", win_ops[OW-1:0] | win_ops[2*OW-1:OW] | win_ops[3*OW-1:2*OW], '0);
      check("arst.rdy", OW'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      check_state("post_rst");
      step("after_rst", 0, 4'b0011, 4'b0000, pack4(E, F, X, X));

      for (int k = 0; k < 400; k++) begin
         step($sformatf("rnd%0d", k), ($urandom_range(0, 24) == 0), 4'($urandom),
              4'($urandom), pack4(rnd_op(), rnd_op(), rnd_op(), rnd_op()));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dispatch_window.md
DISPATCH_WINDOW -- requirements
Module: dispatch_window

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: number of window slots and the input group width.
REQ-002 Operation width SHALL be `RENAMED_OP_SZ`; opcode SHALL be bits [47:44] and destination bits [55:48] of each op; the block SHALL NOT decode them.
REQ-003 Ports, one per line, as name / direction / width / meaning:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all window contents.
- in_ops  in  FETCH_WIDTH*`RENAMED_OP_SZ  renamed op group from rename; slot 0 oldest.
- in_valid  in  FETCH_WIDTH  per-op valid for in_ops.
- in_ready  out  1  the whole valid input group is accepted this cycle.
- win_ops  out  FETCH_WIDTH*`RENAMED_OP_SZ  window contents to the type sorter; slot 0 oldest.
- win_valid  out  FETCH_WIDTH  per-slot valid.
- win_used  in  FETCH_WIDTH  per-slot "consumed this cycle" mask returned by the type sorter.
- occupancy  out  $clog2(FETCH_WIDTH+1)  count of valid slots.

Function
REQ-004 win_ops, win_valid and occupancy SHALL be driven directly from registers, with no combinational path from any input.
REQ-005 win_valid SHALL always be contiguous from slot 0, and occupancy SHALL equal popcount(win_valid).
REQ-006 Effective used mask = win_used & win_valid; win_used bits on invalid slots SHALL be ignored.
REQ-007 win_used MAY be non-contiguous (e.g. 4'b0101).
- Surviving entries (valid & ~used) SHALL shift down to the lowest slots next cycle.
- Their relative program order SHALL be preserved.
REQ-008 Effective input count n_in = length of the contiguous run of in_valid ones starting at bit 0; bits above the first zero SHALL be ignored.
REQ-009 in_ready SHALL be high iff flush=0 and (occupancy - popcount(effective used)) + n_in <= FETCH_WIDTH.
- It is combinational from occupancy, win_used and in_valid.
- There SHALL be no path from in_ops to in_ready.
REQ-010 Acceptance is all-or-nothing: when in_ready=1 and n_in>0, the n_in ops SHALL be written next cycle directly above the surviving entries, in input order.
- When in_ready=0, nothing SHALL be accepted.
REQ-011 Removal and acceptance in the same cycle SHALL both take effect; latency from acceptance to visibility on win_valid is 1 cycle.
REQ-012 A full window (occupancy=FETCH_WIDTH) with win_used=0 SHALL hold all contents unchanged and drop in_ready for any n_in>0.
REQ-013 When n_in=0, in_ready SHALL still reflect the capacity check, and is high whenever flush=0.
REQ-014 flush=1 SHALL force in_ready=0 and ignore win_used and in_valid.
- Next cycle: win_valid=0, occupancy=0.
- flush SHALL take priority over every other event.
REQ-015 Contents of invalid slots in win_ops are don't-care, but SHALL NOT be X after reset (zeroed).

Reset
REQ-016 While rst=1, asynchronously:
- win_valid=0, occupancy=0, win_ops=0.
- in_ready SHALL evaluate per REQ-009, i.e. 1 when flush=0 and n_in<=FETCH_WIDTH.
REQ-017 Reset asserted mid-operation SHALL discard all entries, including any input accepted in that cycle; the first edge after deassertion behaves as an empty window.

Verification
REQ-018 Fill: from reset, in_valid=4'b0111 with ops A,B,C, win_used=0 -> in_ready=1; next cycle win_valid=4'b0111, slots 0..2 = A,B,C, occupancy=2'd3... sized 3'd3.
REQ-019 Compaction: window A,B,C,D with win_used=4'b0101, no input -> next cycle win_valid=4'b0011, slot0=B, slot1=D.
REQ-020 Simultaneous remove and fill: window A,B,C,D with win_used=4'b0011 and in_valid=4'b0011 (E,F) -> in_ready=1; next cycle C,D,E,F, occupancy=4.
REQ-021 Full stall: window full, win_used=0, in_valid=4'b0001 -> in_ready=0; contents unchanged for every stalled cycle.
REQ-022 Non-contiguous input: occupancy=1, in_valid=4'b1101 (P,Q,R) -> n_in=1, in_ready=1; next cycle slot1=P and occupancy=2.
REQ-023 Flush and reset: flush=1 with a full window and valid input -> in_ready=0, next cycle occupancy=0; rst pulsed between clock edges -> outputs immediately zero.
